spi_master_ctrl: RTL

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

---
 rtl/spi_master_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/spi_master_ctrl.sv
// ============================================================================
// spi_master_ctrl : SPI frame master (select bit, cmd+payload, read turnaround)
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_master_ctrl #(
   parameter int ADDR_SIZE  = 8,
   parameter int TURNAROUND = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [1:0]           cmd,
   input  logic [ADDR_SIZE-1:0] wdata,
   output logic                 busy,
   output logic                 done,
   output logic [ADDR_SIZE-1:0] rdata,
   output logic                 MOSI,
   input  logic                 MISO,
   output logic                 SS_N
);

   localparam int FW   = ADDR_SIZE + 2;
   localparam int MAXC = (FW > TURNAROUND) ? FW : TURNAROUND;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [CW-1:0] LAST_SHIFT = CW'(FW - 1);
   localparam logic [CW-1:0] LAST_TURN  = CW'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);
   localparam logic [CW-1:0] LAST_CAP   = CW'(ADDR_SIZE - 1);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SELECT  = 3'd1;
   localparam logic [2:0] S_SHIFT   = 3'd2;
   localparam logic [2:0] S_TURN    = 3'd3;
   localparam logic [2:0] S_CAPTURE = 3'd4;
   localparam logic [2:0] S_FINISH  = 3'd5;

   logic [2:0]           state_q, state_d;
   logic [CW-1:0]        cnt_q,   cnt_d;
   logic [FW-1:0]        shift_q, shift_d;
   logic [ADDR_SIZE-1:0] cap_q,   cap_d;
   logic [ADDR_SIZE-1:0] rdata_q, rdata_d;
   logic                 rd_q,    rd_d;
   logic                 mosi_q,  mosi_d;
   logic                 ssn_q,   ssn_d;
   logic                 busy_q,  busy_d;
   logic                 done_q,  done_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         cap_q   <= '0;
         rdata_q <= '0;
         rd_q    <= 1'b0;
         mosi_q  <= 1'b0;
         ssn_q   <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         cap_q   <= cap_d;
         rdata_q <= rdata_d;
         rd_q    <= rd_d;
         mosi_q  <= mosi_d;
         ssn_q   <= ssn_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      cap_d   = cap_q;
      rdata_d = rdata_q;
      rd_d    = rd_q;
      case (state_q)
         // FINISH already has SS_N high and busy low, so it doubles as the
         // accept slot; back-to-back frames then keep a single SS_N-high gap.
         S_IDLE, S_FINISH: begin
            if (state_q == S_FINISH && rd_q) begin
               rdata_d = cap_q;
            end
            state_d = S_IDLE;
            if (start) begin
               state_d = S_SELECT;
               cnt_d   = '0;
               cap_d   = '0;
               rd_d    = (cmd == 2'b11);
               shift_d = (cmd == 2'b11) ? {2'b11, {ADDR_SIZE{1'b0}}} : {cmd, wdata};
            end
         end
         S_SELECT: begin
            state_d = S_SHIFT;
            cnt_d   = '0;
         end
         S_SHIFT: begin
            shift_d = {shift_q[FW-2:0], 1'b0};
            if (cnt_q == LAST_SHIFT) begin
               cnt_d = '0;
               if (!rd_q) begin
                  state_d = S_FINISH;
               end else if (TURNAROUND == 0) begin
                  state_d = S_CAPTURE;
               end else begin
                  state_d = S_TURN;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_TURN: begin
            if (cnt_q == LAST_TURN) begin
               cnt_d   = '0;
               state_d = S_CAPTURE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_CAPTURE: begin
            cap_d = {cap_q[ADDR_SIZE-2:0], MISO};
            if (cnt_q == LAST_CAP) begin
               cnt_d   = '0;
               state_d = S_FINISH;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state and registered with it.
   always_comb begin
      mosi_d = 1'b0;
      ssn_d  = 1'b1;
      busy_d = 1'b0;
      done_d = 1'b0;
      case (state_d)
         S_SELECT, S_SHIFT: begin
            mosi_d = shift_d[FW-1];
            ssn_d  = 1'b0;
            busy_d = 1'b1;
         end
         S_TURN, S_CAPTURE: begin
            ssn_d  = 1'b0;
            busy_d = 1'b1;
         end
         S_FINISH: begin
            done_d = 1'b1;
         end
         default: begin
            mosi_d = 1'b0;
         end
      endcase
   end

   assign MOSI  = mosi_q;
   assign SS_N  = ssn_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign rdata = rdata_q;

endmodule

`default_nettype wire
